exposure_timer: RTL and testbench
=================================

// Module: exposure_timer
// PURPOSE
//  Parametrised exposure timer for the camera control path.
//  - On Start: latch exposure length, hold Expose high for exactly that many ticks, then pulse Done.
//  - Supports abort, zero-length requests, an elapsed-count readout and an optional tick prescaler.
//  - Sits between the camera control FSM (Start/Abort) and the pixel-array expose/erase drivers.
// PARAMETERS
//  TIME_W    5     width of Exp_Time and Elapsed (max exposure 2^TIME_W-1 ticks)
//  PRESCALE  1000  clocks per tick when EXP_TIMER_PRESCALE_EN is defined (>=2); unused otherwise
// PORTS
//  Clk       in   1       single clock; all logic on posedge Clk
//  Reset     in   1       asynchronous, active-low reset (0 = reset)
//  Start     in   1       level, sampled in IDLE only; request one exposure
//  Abort     in   1       level; terminate exposure, no Done
//  Exp_Time  in   TIME_W  exposure length in ticks; sampled when Start is accepted
//  Expose    out  1       high while exposure is in progress
//  Busy      out  1       high in any state other than IDLE
//  Done      out  1       1-cycle pulse at normal completion
//  Aborted   out  1       1-cycle pulse when an exposure is aborted
//  Elapsed   out  TIME_W  ticks completed in current exposure; holds final value until next Start
// BEHAVIOUR
//  - Reset (Reset=0, async): state=IDLE.
//    - Expose=0, Busy=0, Done=0, Aborted=0, Elapsed=0, time_q=0, prescaler=0.
//  - States: IDLE, EXPOSE, DONE, ABORT. All outputs are registered.
//  - IDLE
//    - Abort=1: stay in IDLE; Abort takes priority over a simultaneous Start.
//    - Else Start=1: time_q<=Exp_Time, Elapsed<=0, prescaler<=0.
//      - Exp_Time==0: go to DONE; Expose is never asserted.
//      - Else: go to EXPOSE.
//  - EXPOSE: Expose=1, Busy=1.
//    - Each tick: Elapsed<=Elapsed+1.
//    - On the tick where Elapsed+1==time_q: go to DONE.
//    - Abort=1: go to ABORT, checked before the tick; Elapsed freezes.
//  - DONE: Done=1 and Busy=1 for one cycle, Expose=0, then IDLE.
//  - ABORT: Aborted=1 and Busy=1 for one cycle, Expose=0, then IDLE.
//  - Tick without prescaler: every clock.
//  - Timing (no prescaler), Start accepted at edge k with N>0:
//    - Expose high for cycles k+1..k+N (exactly N cycles).
//    - Done high in cycle k+N+1.
//    - Next Start accepted at the edge ending cycle k+N+2 at the earliest.
//  - Start is ignored while Busy; there is no queueing.
//  - Exp_Time changes after acceptance have no effect.
//  - Elapsed never wraps: terminal count is <= 2^TIME_W-1, so no overflow is possible.
//  - Start held high: a new exposure starts on each return to IDLE (back-to-back exposures).
// CONFIGURATION
//  EXP_TIMER_PRESCALE_EN
//   - Defined: a tick occurs once every PRESCALE clocks while in EXPOSE.
//     - Prescaler clears on Start acceptance, so the first tick falls PRESCALE clocks after entering EXPOSE.
//     - Expose is high for exactly N*PRESCALE cycles.
//   - Undefined: tick = every clock; prescaler logic absent; PRESCALE ignored.
// STRUCTURE
//  - Shared package exposure_timer_pkg:
//    - State encoding constants: IDLE=2'd0, EXPOSE=2'd1, DONE=2'd2, ABORT=2'd3.
//    - Default TIME_W and PRESCALE values, shared with the camera control FSM.
//  - Sub-module tick_prescaler (PRESCALE):
//    - Ports: clr, en in; tick out.
//    - Instantiated only under EXP_TIMER_PRESCALE_EN.
//  - Top level holds the FSM, time_q and the Elapsed counter.
// TESTING
//  1 Reset=0 mid-EXPOSE (Exp_Time=20, at Elapsed=7): all outputs 0 asynchronously; after release stays IDLE.
//  2 No prescaler, Exp_Time=5, Start 1 cycle: Expose high exactly 5 cycles, Done 1 cycle after, Elapsed=5.
//  3 Exp_Time=0, Start: no Expose, Done pulses next cycle, Elapsed=0; Exp_Time=31: Expose 31 cycles.
//  4 Exp_Time=10, Abort at Elapsed=4: Expose drops next cycle, Aborted 1 cycle, no Done, Elapsed=4.
//  5 Start held high, Exp_Time=3; Exp_Time changed to 9 mid-exposure: 1st exposure 3 cycles; next starts 2 cycles after Expose falls with 9.
//  6 EXP_TIMER_PRESCALE_EN, PRESCALE=4, Exp_Time=3: Expose exactly 12 cycles; Elapsed steps every 4th clock.

Source files
------------

// File: rtl/exposure_timer_pkg.sv
// Shared definitions for the exposure timer and the camera control FSM:
// state encoding and default sizing.
package exposure_timer_pkg;

  localparam int TIME_W_DEF   = 5;
  localparam int PRESCALE_DEF = 1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPOSE = 2'd1,
    DONE   = 2'd2,
    ABORT  = 2'd3
  } state_e;

endpackage

// File: rtl/exposure_timer_tick_prescaler.sv
// Tick generator: one-cycle tick every PRESCALE enabled clocks.
// Used by exposure_timer only when EXP_TIMER_PRESCALE_EN is defined.
module tick_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      // Tick on the last clock of each period so the first tick lands
      // exactly PRESCALE enabled clocks after a clear.
      if (cnt_q == CNT_W'(PRESCALE - 1)) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/exposure_timer.sv
// Exposure timer: latches Exp_Time on Start, holds Expose for that many ticks,
// then pulses Done (or Aborted). Optional tick prescaler via EXP_TIMER_PRESCALE_EN.
module exposure_timer
  import exposure_timer_pkg::*;
#(
  parameter int TIME_W   = TIME_W_DEF,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [TIME_W-1:0] Exp_Time,
  output logic              Expose,
  output logic              Busy,
  output logic              Done,
  output logic              Aborted,
  output logic [TIME_W-1:0] Elapsed,
  output logic [1:0]        state_dbg
);

  state_e            state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [TIME_W-1:0] elapsed_q, elapsed_d;
  logic [TIME_W-1:0] elapsed_inc;
  logic              expose_q, expose_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              start_acc;
  logic              tick;

`ifdef EXP_TIMER_PRESCALE_EN
  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (Clk),
    .rst_n (Reset),
    .clr   (start_acc),
    .en    ((state_q == EXPOSE) && !Abort),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign elapsed_inc = elapsed_q + TIME_W'(1);

  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    elapsed_d = elapsed_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        // Abort wins over a simultaneous Start.
        if (!Abort && Start) begin
          start_acc = 1'b1;
          time_d    = Exp_Time;
          elapsed_d = '0;
          state_d   = (Exp_Time == '0) ? DONE : EXPOSE;
        end
      end
      EXPOSE: begin
        if (Abort) begin
          state_d = ABORT;
        end else if (tick) begin
          elapsed_d = elapsed_inc;
          if (elapsed_inc == time_q) state_d = DONE;
        end
      end
      DONE, ABORT: state_d = IDLE;
      default:     state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    expose_d  = (state_d == EXPOSE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    aborted_d = (state_d == ABORT);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      time_q    <= '0;
      elapsed_q <= '0;
      expose_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      elapsed_q <= elapsed_d;
      expose_q  <= expose_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign Expose    = expose_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Aborted   = aborted_q;
  assign Elapsed   = elapsed_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_exposure_timer.sv
// Self-checking bench for exposure_timer: directed scenarios plus randomized
// exposures/aborts checked against a cycle-count model of the timer's rules.
module tb_exposure_timer;
  import exposure_timer_pkg::*;

  localparam int W = 5;
`ifdef EXP_TIMER_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  // Clock/reset
  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic         Abort = 1'b0;
  logic [W-1:0] Exp_Time = '0;
  logic         Expose, Busy, Done, Aborted;
  logic [W-1:0] Elapsed;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 Clk = ~Clk;

  exposure_timer #(.TIME_W(W), .PRESCALE(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Abort     (Abort),
    .Exp_Time  (Exp_Time),
    .Expose    (Expose),
    .Busy      (Busy),
    .Done      (Done),
    .Aborted   (Aborted),
    .Elapsed   (Elapsed),
    .state_dbg (state_dbg)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // One exposure of n ticks; abort_at>0 raises Abort for the clock cycle with
  // that index (cycle 1 = first cycle after the Start edge).
  task automatic run_one(input int n, input int abort_at, input string tag);
    int exp_last, exp_pulse;
    int ex_cnt, ex_first, ex_last, done_c, done_n, ab_c, ab_n, busy_n, el_bad;
    logic [W-1:0] exp_el;
    exp_last  = (abort_at > 0) ? abort_at : n * P;
    exp_pulse = exp_last + 1;
    exp_q.push_back((abort_at > 0) ? W'((abort_at - 1) / P) : W'(n));
    ex_cnt = 0; ex_first = 0; ex_last = 0; done_c = 0; done_n = 0;
    ab_c = 0; ab_n = 0; busy_n = 0; el_bad = 0;

    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_before: Busy=%0b expected 0", tag, Busy);
    end
    Start = 1'b1; Exp_Time = W'(n); Abort = 1'b0;
    for (int c = 1; c <= n * P + 5; c++) begin
      @(negedge Clk);
      if (Expose) begin
        ex_cnt++;
        if (ex_first == 0) ex_first = c;
        ex_last = c;
        if (Elapsed !== W'((c - 1) / P)) el_bad++;
      end
      if (Done) begin done_n++; done_c = c; end
      if (Aborted) begin ab_n++; ab_c = c; end
      if (Busy) busy_n++;
      Start    = 1'b0;
      Exp_Time = W'($urandom_range(0, 31));
      Abort    = (c == abort_at);
    end
    Abort = 1'b0;

    checks++;
    if (ex_cnt !== exp_last) begin
      errors++;
      $display("FAIL %s_expose_cycles: got %0d expected %0d", tag, ex_cnt, exp_last);
    end
    checks++;
    if (ex_first !== ((exp_last > 0) ? 1 : 0) || ex_last !== exp_last) begin
      errors++;
      $display("FAIL %s_expose_window: got %0d..%0d expected %0d..%0d", tag, ex_first, ex_last,
               (exp_last > 0) ? 1 : 0, exp_last);
    end
    checks++;
    if (el_bad !== 0) begin
      errors++;
      $display("FAIL %s_elapsed_steps: got %0d bad cycles expected 0", tag, el_bad);
    end
    checks++;
    if (busy_n !== exp_pulse) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d expected %0d", tag, busy_n, exp_pulse);
    end
    if (abort_at > 0) begin
      checks++;
      if (ab_n !== 1 || ab_c !== exp_pulse || done_n !== 0) begin
        errors++;
        $display("FAIL %s_aborted_pulse: got n=%0d at %0d done=%0d expected n=1 at %0d done=0",
                 tag, ab_n, ab_c, done_n, exp_pulse);
      end
    end else begin
      checks++;
      if (done_n !== 1 || done_c !== exp_pulse || ab_n !== 0) begin
        errors++;
        $display("FAIL %s_done_pulse: got n=%0d at %0d aborted=%0d expected n=1 at %0d aborted=0",
                 tag, done_n, done_c, ab_n, exp_pulse);
      end
    end
    exp_el = exp_q.pop_front();
    checks++;
    if (Elapsed !== exp_el) begin
      errors++;
      $display("FAIL %s_final_elapsed: got %0d expected %0d", tag, Elapsed, exp_el);
    end
  endtask

  task automatic test_reset_init();
    repeat (3) @(negedge Clk);
    checks++;
    if ({Expose, Busy, Done, Aborted, Elapsed, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_init: got E=%0b B=%0b D=%0b A=%0b El=%0d st=%0d expected all 0",
               Expose, Busy, Done, Aborted, Elapsed, state_dbg);
    end
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_release_idle: got B=%0b st=%0d expected 0,0", Busy, state_dbg);
    end
  endtask

  task automatic test_basic();
    run_one(5, 0, "basic5");
  endtask

  task automatic test_zero_and_max();
    run_one(0, 0, "zero");
    run_one(31, 0, "max31");
  endtask

  task automatic test_abort();
    run_one(10, 4 * P + 1, "abort_el4");
    run_one(6, 6 * P, "abort_last");
    run_one(7, 1, "abort_first");
  endtask

  task automatic test_abort_priority();
    @(negedge Clk);
    Start = 1'b1; Abort = 1'b1; Exp_Time = 5'd7;
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || Expose !== 1'b0) begin
      errors++;
      $display("FAIL abort_priority: got B=%0b E=%0b expected 0,0", Busy, Expose);
    end
    Start = 1'b0; Abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    int total, ex_bad, dn_bad;
    logic ex_e, dn_e;
    total = 12 * P + 5;
    ex_bad = 0; dn_bad = 0;
    @(negedge Clk);
    Start = 1'b1; Exp_Time = 5'd3;
    for (int c = 1; c <= total; c++) begin
      @(negedge Clk);
      ex_e = (c >= 1 && c <= 3 * P) || (c >= 3 * P + 3 && c <= 12 * P + 2);
      dn_e = (c == 3 * P + 1) || (c == 12 * P + 3);
      if (Expose !== ex_e) ex_bad++;
      if (Done !== dn_e) dn_bad++;
      if (c == 2) Exp_Time = 5'd9;
      if (c == 3 * P + 3) Start = 1'b0;
    end
    checks++;
    if (ex_bad !== 0) begin
      errors++;
      $display("FAIL b2b_expose_pattern: got %0d wrong cycles expected 0", ex_bad);
    end
    checks++;
    if (dn_bad !== 0) begin
      errors++;
      $display("FAIL b2b_done_pattern: got %0d wrong cycles expected 0", dn_bad);
    end
    checks++;
    if (Elapsed !== 5'd9 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final: got El=%0d B=%0b expected 9,0", Elapsed, Busy);
    end
  endtask

  task automatic test_random();
    int n, ab;
    for (int i = 0; i < 16; i++) begin
      n  = $urandom_range(0, 31);
      ab = 0;
      if (n > 0 && $urandom_range(0, 1) == 1) ab = $urandom_range(1, n * P);
      run_one(n, ab, $sformatf("rand%0d", i));
    end
  endtask

`ifdef EXP_TIMER_PRESCALE_EN
  task automatic test_prescale();
    run_one(3, 0, "prescale3");
  endtask
`endif

  task automatic test_reset_mid();
    int guard;
    @(negedge Clk);
    Start = 1'b1; Exp_Time = 5'd20;
    @(negedge Clk);
    Start = 1'b0;
    guard = 0;
    while (Elapsed !== 5'd7 && guard < 400) begin
      @(negedge Clk);
      guard++;
    end
    checks++;
    if (Elapsed !== 5'd7 || Expose !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_reach7: got El=%0d E=%0b expected 7,1", Elapsed, Expose);
    end
    #2 Reset = 1'b0;
    #1;
    checks++;
    if ({Expose, Busy, Done, Aborted, Elapsed, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got E=%0b B=%0b D=%0b A=%0b El=%0d st=%0d expected all 0",
               Expose, Busy, Done, Aborted, Elapsed, state_dbg);
    end
    @(negedge Clk);
    Reset = 1'b1;
    repeat (5) @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || Expose !== 1'b0 || Elapsed !== '0) begin
      errors++;
      $display("FAIL reset_mid_after: got B=%0b E=%0b El=%0d expected 0,0,0", Busy, Expose, Elapsed);
    end
  endtask

  initial begin
    test_reset_init();
    test_basic();
    test_zero_and_max();
    test_abort();
    test_abort_priority();
    test_back_to_back();
    test_random();
`ifdef EXP_TIMER_PRESCALE_EN
    test_prescale();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
